// File: rtl/in_decode.sv
// Instruction-decode stage: splits the fetched RV32I word into fields, reads the
// register file (with write-through from writeback), builds the immediate and the
// control word, detects load-use hazards and registers everything into ID/EX.
module in_decode #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     instruction_in,
   input  logic [XLEN-1:0] PC_in,
   input  logic            PCSrc,
   input  logic            MemRead_ex,
   input  logic [4:0]      rd_ex,
   input  logic            RegWrite_wb,
   input  logic [4:0]      rd_wb,
   input  logic [XLEN-1:0] wdata_wb,
   output logic            PCWrite,
   output logic [XLEN-1:0] PC_out,
   output logic [XLEN-1:0] rs1_data_out,
   output logic [XLEN-1:0] rs2_data_out,
   output logic [XLEN-1:0] imm_out,
   output logic [4:0]      rs1_out,
   output logic [4:0]      rs2_out,
   output logic [4:0]      rd_out,
   output logic [2:0]      funct3_out,
   output logic            funct7b5_out,
   output logic            RegWrite_out,
   output logic            MemRead_out,
   output logic            MemWrite_out,
   output logic            Branch_out,
   output logic            Jump_out,
   output logic            ALUSrc_out,
   output logic            MemtoReg_out,
   output logic [1:0]      ALUOp_out
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BRANCH= 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   logic [XLEN-1:0] regs [NREGS];

   logic [6:0]             opcode_p0;
   logic [4:0]             rs1_idx_p0;
   logic [4:0]             rs2_idx_p0;
   logic [XLEN-1:0]        rs1_data_p0;
   logic [XLEN-1:0]        rs2_data_p0;
   logic signed [XLEN-1:0] imm_p0;
   logic                   reg_write_p0;
   logic                   mem_read_p0;
   logic                   mem_write_p0;
   logic                   branch_p0;
   logic                   jump_p0;
   logic                   alu_src_p0;
   logic                   mem_to_reg_p0;
   logic [1:0]             alu_op_p0;
   logic                   use_rs1_p0;
   logic                   use_rs2_p0;
   logic                   lui_p0;
   logic                   hazard_p0;

   // Sign-extended immediate for the instruction format implied by the opcode
   function automatic logic signed [XLEN-1:0] imm_gen(input logic [31:0] ins);
      logic signed [XLEN-1:0] imm;
      case (ins[6:0])
         OP_IALU, OP_LOAD, OP_JALR: imm = XLEN'($signed(ins[31:20]));
         OP_STORE:  imm = XLEN'($signed({ins[31:25], ins[11:7]}));
         OP_BRANCH: imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         OP_LUI, OP_AUIPC: imm = XLEN'($signed({ins[31:12], 12'b0}));
         OP_JAL:    imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         default:   imm = '0;
      endcase
      return imm;
   endfunction

   // Register read with write-through so an instruction sees same-cycle writeback
   function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
      logic [XLEN-1:0] val;
      if (idx == 5'd0)
         val = '0;
      else if (RegWrite_wb && (rd_wb == idx))
         val = wdata_wb;
      else
         val = regs[idx];
      return val;
   endfunction

   assign opcode_p0 = instruction_in[6:0];

   // Opcode decode into control bits and source-usage flags
   always_comb begin
      reg_write_p0  = 1'b0;
      mem_read_p0   = 1'b0;
      mem_write_p0  = 1'b0;
      branch_p0     = 1'b0;
      jump_p0       = 1'b0;
      alu_src_p0    = 1'b0;
      mem_to_reg_p0 = 1'b0;
      alu_op_p0     = 2'b00;
      use_rs1_p0    = 1'b1;
      use_rs2_p0    = 1'b0;
      lui_p0        = 1'b0;
      case (opcode_p0)
         OP_R: begin
            reg_write_p0 = 1'b1;
            alu_op_p0    = 2'b10;
            use_rs2_p0   = 1'b1;
         end
         OP_IALU: begin
            reg_write_p0 = 1'b1;
            alu_src_p0   = 1'b1;
            alu_op_p0    = 2'b11;
         end
         OP_LOAD: begin
            reg_write_p0  = 1'b1;
            mem_read_p0   = 1'b1;
            mem_to_reg_p0 = 1'b1;
            alu_src_p0    = 1'b1;
         end
         OP_STORE: begin
            mem_write_p0 = 1'b1;
            alu_src_p0   = 1'b1;
            use_rs2_p0   = 1'b1;
         end
         OP_BRANCH: begin
            branch_p0  = 1'b1;
            alu_op_p0  = 2'b01;
            use_rs2_p0 = 1'b1;
         end
         OP_JAL: begin
            reg_write_p0 = 1'b1;
            jump_p0      = 1'b1;
            use_rs1_p0   = 1'b0;
         end
         OP_JALR: begin
            reg_write_p0 = 1'b1;
            jump_p0      = 1'b1;
            alu_src_p0   = 1'b1;
         end
         OP_LUI: begin
            reg_write_p0 = 1'b1;
            alu_src_p0   = 1'b1;
            use_rs1_p0   = 1'b0;
            lui_p0       = 1'b1;
         end
         OP_AUIPC: begin
            reg_write_p0 = 1'b1;
            alu_src_p0   = 1'b1;
            use_rs1_p0   = 1'b0;
         end
         default: ;
      endcase
   end

   // LUI has no rs1; forcing the index to x0 also makes its operand read zero
   assign rs1_idx_p0  = lui_p0 ? 5'd0 : instruction_in[19:15];
   assign rs2_idx_p0  = instruction_in[24:20];
   assign rs1_data_p0 = rf_read(rs1_idx_p0);
   assign rs2_data_p0 = rf_read(rs2_idx_p0);
   assign imm_p0      = imm_gen(instruction_in);

   assign hazard_p0 = MemRead_ex && (rd_ex != 5'd0) &&
                      ((use_rs1_p0 && (rd_ex == rs1_idx_p0)) ||
                       (use_rs2_p0 && (rd_ex == rs2_idx_p0)));

   // A taken branch squashes this instruction anyway, and fetch would let a
   // hold request mask the redirect, so the stall is dropped while PCSrc is high
   assign PCWrite = hazard_p0 && !PCSrc;

   // Register file: cleared on reset, x0 never written
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (RegWrite_wb && (rd_wb != 5'd0)) begin
         regs[rd_wb] <= wdata_wb;
      end
   end

   // ---- ID/EX boundary: reset > flush > load-use bubble > normal load ----
   always_ff @(posedge clk) begin
      if (reset || PCSrc) begin
         PC_out       <= '0;
         rs1_data_out <= '0;
         rs2_data_out <= '0;
         imm_out      <= '0;
         rs1_out      <= '0;
         rs2_out      <= '0;
         rd_out       <= '0;
         funct3_out   <= '0;
         funct7b5_out <= 1'b0;
         RegWrite_out <= 1'b0;
         MemRead_out  <= 1'b0;
         MemWrite_out <= 1'b0;
         Branch_out   <= 1'b0;
         Jump_out     <= 1'b0;
         ALUSrc_out   <= 1'b0;
         MemtoReg_out <= 1'b0;
         ALUOp_out    <= 2'b00;
      end else begin
         PC_out       <= PC_in;
         rs1_data_out <= rs1_data_p0;
         rs2_data_out <= rs2_data_p0;
         imm_out      <= imm_p0;
         rs1_out      <= rs1_idx_p0;
         rs2_out      <= rs2_idx_p0;
         rd_out       <= instruction_in[11:7];
         funct3_out   <= instruction_in[14:12];
         funct7b5_out <= instruction_in[30];
         RegWrite_out <= reg_write_p0  && !hazard_p0;
         MemRead_out  <= mem_read_p0   && !hazard_p0;
         MemWrite_out <= mem_write_p0  && !hazard_p0;
         Branch_out   <= branch_p0     && !hazard_p0;
         Jump_out     <= jump_p0       && !hazard_p0;
         ALUSrc_out   <= alu_src_p0    && !hazard_p0;
         MemtoReg_out <= mem_to_reg_p0 && !hazard_p0;
         ALUOp_out    <= hazard_p0 ? 2'b00 : alu_op_p0;
      end
   end

endmodule

// File: tb/tb_in_decode.sv
// Bench for in_decode: directed cases with literal expectations, then random
// instruction/hazard/writeback traffic checked every cycle against a model.
module tb_in_decode;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instruction_in;
   logic [31:0] PC_in;
   logic        PCSrc;
   logic        MemRead_ex;
   logic [4:0]  rd_ex;
   logic        RegWrite_wb;
   logic [4:0]  rd_wb;
   logic [31:0] wdata_wb;
   logic        PCWrite;
   logic [31:0] PC_out, rs1_data_out, rs2_data_out, imm_out;
   logic [4:0]  rs1_out, rs2_out, rd_out;
   logic [2:0]  funct3_out;
   logic        funct7b5_out;
   logic        RegWrite_out, MemRead_out, MemWrite_out, Branch_out;
   logic        Jump_out, ALUSrc_out, MemtoReg_out;
   logic [1:0]  ALUOp_out;

   int total = 0;
   int bad   = 0;

   in_decode #(.XLEN(32), .NREGS(32)) dut (
      .clk(clk), .reset(reset), .instruction_in(instruction_in), .PC_in(PC_in),
      .PCSrc(PCSrc), .MemRead_ex(MemRead_ex), .rd_ex(rd_ex),
      .RegWrite_wb(RegWrite_wb), .rd_wb(rd_wb), .wdata_wb(wdata_wb),
      .PCWrite(PCWrite), .PC_out(PC_out), .rs1_data_out(rs1_data_out),
      .rs2_data_out(rs2_data_out), .imm_out(imm_out), .rs1_out(rs1_out),
      .rs2_out(rs2_out), .rd_out(rd_out), .funct3_out(funct3_out),
      .funct7b5_out(funct7b5_out), .RegWrite_out(RegWrite_out),
      .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
      .Branch_out(Branch_out), .Jump_out(Jump_out), .ALUSrc_out(ALUSrc_out),
      .MemtoReg_out(MemtoReg_out), .ALUOp_out(ALUOp_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc, d1, d2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic        f7;
      logic [6:0]  ctl;   // RegWrite MemRead MemWrite Branch Jump ALUSrc MemtoReg
      logic [1:0]  aluop;
   } idex_t;

   logic [31:0] mregs [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mread(input logic [4:0] i);
      if (i == 5'd0) return 32'd0;
      if (RegWrite_wb && rd_wb == i) return wdata_wb;
      return mregs[i];
   endfunction

   function automatic logic hazard_model(input logic [31:0] ins);
      logic [6:0] op;
      logic u1, u2;
      op = ins[6:0];
      u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
      u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
      return MemRead_ex && rd_ex != 5'd0 &&
             ((u1 && rd_ex == ins[19:15]) || (u2 && rd_ex == ins[24:20]));
   endfunction

   function automatic idex_t model(input logic [31:0] ins, input logic [31:0] pc);
      idex_t e;
      int v;
      e = '0;
      e.pc = pc; e.rd = ins[11:7]; e.f3 = ins[14:12]; e.f7 = ins[30];
      e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
      case (ins[6:0])
         7'h33: begin e.ctl = 7'b1000000; e.aluop = 2'd2; end
         7'h13, 7'h03, 7'h67: begin
            if (ins[6:0] == 7'h13) begin e.ctl = 7'b1000010; e.aluop = 2'd3; end
            else if (ins[6:0] == 7'h03) e.ctl = 7'b1100011;
            else e.ctl = 7'b1000110;
            v = int'(ins[31:20]);
            if (ins[31]) v -= 4096;
            e.imm = 32'(v);
         end
         7'h23: begin
            e.ctl = 7'b0010010;
            v = int'({ins[31:25], ins[11:7]});
            if (ins[31]) v -= 4096;
            e.imm = 32'(v);
         end
         7'h63: begin
            e.ctl = 7'b0001000; e.aluop = 2'd1;
            v = int'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
            if (ins[31]) v -= 8192;
            e.imm = 32'(v);
         end
         7'h6F: begin
            e.ctl = 7'b1000100;
            v = int'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
            if (ins[31]) v -= 2097152;
            e.imm = 32'(v);
         end
         7'h37, 7'h17: begin
            e.ctl = 7'b1000010;
            e.imm = ins & 32'hFFFFF000;
            if (ins[6:0] == 7'h37) e.rs1 = 5'd0;
         end
         default: ;
      endcase
      e.d1 = mread(e.rs1);
      e.d2 = mread(e.rs2);
      return e;
   endfunction

   // Per-cycle comparison of every registered output and the stall request
   idex_t e_c;
   logic  hz_c, epw_c, ctl_only_c;
   always @(posedge clk) begin
      e_c = model(instruction_in, PC_in);
      hz_c = hazard_model(instruction_in);
      epw_c = hz_c && !PCSrc;
      ctl_only_c = 1'b0;
      if (reset) begin
         e_c = '0;
         for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      end else begin
         if (PCSrc) e_c = '0;
         else if (hz_c) begin
            e_c.ctl = 7'd0; e_c.aluop = 2'd0; ctl_only_c = 1'b1;
         end
         if (RegWrite_wb && rd_wb != 5'd0) mregs[rd_wb] = wdata_wb;
      end
      #1;
      chk("pcwrite", 32'(PCWrite), 32'(epw_c));
      chk("ctl", 32'({RegWrite_out, MemRead_out, MemWrite_out, Branch_out,
                      Jump_out, ALUSrc_out, MemtoReg_out}), 32'(e_c.ctl));
      chk("aluop", 32'(ALUOp_out), 32'(e_c.aluop));
      if (!ctl_only_c) begin
         chk("pc", PC_out, e_c.pc);
         chk("rs1_data", rs1_data_out, e_c.d1);
         chk("rs2_data", rs2_data_out, e_c.d2);
         chk("imm", imm_out, e_c.imm);
         chk("idx", 32'({rs1_out, rs2_out, rd_out}), 32'({e_c.rs1, e_c.rs2, e_c.rd}));
         chk("funct", 32'({funct3_out, funct7b5_out}), 32'({e_c.f3, e_c.f7}));
      end
   end

   task automatic idle_side();
      PCSrc = 1'b0; MemRead_ex = 1'b0; rd_ex = 5'd0;
      RegWrite_wb = 1'b0; rd_wb = 5'd0; wdata_wb = 32'd0;
   endtask

   task automatic edge_then_settle();
      @(posedge clk);
      #2;
   endtask

   logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                            7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};

   initial begin
      reset = 1'b1; instruction_in = 32'd0; PC_in = 32'd0;
      idle_side();
      repeat (2) @(posedge clk);

      // bubble out of reset
      @(negedge clk); reset = 1'b0; instruction_in = 32'd0;
      edge_then_settle();
      chk("t1_regwrite", 32'(RegWrite_out), 32'd0);
      chk("t1_pc", PC_out, 32'd0);
      chk("t1_imm", imm_out, 32'd0);
      chk("t1_pcwrite", 32'(PCWrite), 32'd0);

      // write-through on add x6,x5,x5
      @(negedge clk); instruction_in = 32'h00528333; PC_in = 32'h40;
      RegWrite_wb = 1'b1; rd_wb = 5'd5; wdata_wb = 32'hDEADBEEF;
      edge_then_settle();
      chk("t2_rs1_data", rs1_data_out, 32'hDEADBEEF);
      chk("t2_rs2_data", rs2_data_out, 32'hDEADBEEF);
      chk("t2_rd", 32'(rd_out), 32'd6);
      chk("t2_regwrite", 32'(RegWrite_out), 32'd1);
      chk("t2_aluop", 32'(ALUOp_out), 32'd2);

      // stored value read back from the array, no bypass
      @(negedge clk); idle_side();
      edge_then_settle();
      chk("t2_stored", rs1_data_out, 32'hDEADBEEF);

      // x0 writes are dropped, also through the bypass path
      @(negedge clk); instruction_in = 32'h00000333;
      RegWrite_wb = 1'b1; rd_wb = 5'd0; wdata_wb = 32'h1234;
      edge_then_settle();
      chk("t3_x0_same", rs1_data_out, 32'd0);
      @(negedge clk); idle_side();
      edge_then_settle();
      chk("t3_x0_later", rs1_data_out, 32'd0);

      // load-use stall on rs1=x5, with a writeback in the same cycle
      @(negedge clk); instruction_in = 32'h00028333; MemRead_ex = 1'b1; rd_ex = 5'd5;
      RegWrite_wb = 1'b1; rd_wb = 5'd7; wdata_wb = 32'h77;
      #1 chk("t4_pcwrite", 32'(PCWrite), 32'd1);
      edge_then_settle();
      chk("t4_regwrite", 32'(RegWrite_out), 32'd0);
      chk("t4_aluop", 32'(ALUOp_out), 32'd0);

      // rd_ex = x0 is never a hazard
      @(negedge clk); RegWrite_wb = 1'b0; rd_ex = 5'd0;
      #1 chk("t5_pcwrite", 32'(PCWrite), 32'd0);
      edge_then_settle();
      chk("t5_regwrite", 32'(RegWrite_out), 32'd1);

      // flush masks the stall request
      @(negedge clk); rd_ex = 5'd5; PCSrc = 1'b1;
      #1 chk("t6_pcwrite", 32'(PCWrite), 32'd0);
      edge_then_settle();
      chk("t6_regwrite", 32'(RegWrite_out), 32'd0);
      chk("t6_rd", 32'(rd_out), 32'd0);

      // flushed beq
      @(negedge clk); idle_side(); PCSrc = 1'b1;
      instruction_in = 32'hFE000EE3; PC_in = 32'h100;
      edge_then_settle();
      chk("t7_imm", imm_out, 32'd0);
      chk("t7_branch", 32'(Branch_out), 32'd0);
      chk("t7_pc", PC_out, 32'd0);

      // same beq, not flushed
      @(negedge clk); PCSrc = 1'b0;
      edge_then_settle();
      chk("t8_imm", imm_out, 32'hFFFFFFFC);
      chk("t8_branch", 32'(Branch_out), 32'd1);
      chk("t8_pc", PC_out, 32'h100);
      chk("t8_aluop", 32'(ALUOp_out), 32'd1);

      // jal with most-negative offset; x8 loaded so lui's forced rs1 is visible
      @(negedge clk); instruction_in = 32'h800000EF;
      RegWrite_wb = 1'b1; rd_wb = 5'd8; wdata_wb = 32'h55;
      edge_then_settle();
      chk("t9_imm", imm_out, 32'hFFF00000);
      chk("t9_jump", 32'(Jump_out), 32'd1);
      chk("t9_rd", 32'(rd_out), 32'd1);

      // lui x10 (rs1 field is 8)
      @(negedge clk); idle_side(); instruction_in = 32'h12345537;
      edge_then_settle();
      chk("t10_imm", imm_out, 32'h12345000);
      chk("t10_rs1", 32'(rs1_out), 32'd0);
      chk("t10_rs1_data", rs1_data_out, 32'd0);
      chk("t10_rd", 32'(rd_out), 32'd10);

      // random traffic, small register range to provoke hazards and bypass
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         reset = (n == 300);
         begin
            logic [31:0] ins;
            int k;
            ins = $urandom;
            k = int'($urandom_range(0, 10));
            ins[6:0] = (k == 10) ? 7'($urandom) : ops[k];
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            ins[11:7]  = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) ins = 32'd0;
            instruction_in = ins;
         end
         PC_in       = $urandom;
         PCSrc       = ($urandom_range(0, 7) == 0);
         MemRead_ex  = ($urandom_range(0, 2) == 0);
         rd_ex       = 5'($urandom_range(0, 7));
         RegWrite_wb = ($urandom_range(0, 1) == 0);
         rd_wb       = 5'($urandom_range(0, 7));
         wdata_wb    = $urandom;
      end

      @(negedge clk); idle_side(); instruction_in = 32'd0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/in_decode.md
Name: in_decode

Overview:
- Instruction-decode stage: the consumer end of the fetch interface. Takes the fetched instruction and PC, decodes RV32I fields, reads the register file, and generates immediates and control.
- Registers all results into the ID/EX pipeline register.
- Owns load-use hazard detection and drives the fetch-side hold signal PCWrite (1 = hold PC and IF/ID).
- Sits between the fetch stage and execute; writeback feeds back into its register file.

Parameters:
- XLEN, 32, datapath width
- NREGS, 32, architectural register count (x0 hardwired to zero)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instruction_in  in  32  instruction from fetch (32'b0 = bubble)
- PC_in  in  32  PC of instruction_in
- PCSrc  in  1  branch/jump taken in EX; flush
- MemRead_ex  in  1  instruction currently in EX is a load
- rd_ex  in  5  destination register of the instruction in EX
- RegWrite_wb  in  1  writeback enable
- rd_wb  in  5  writeback destination
- wdata_wb  in  32  writeback data
- PCWrite  out  1  combinational stall request to fetch (1 = hold)
- PC_out  out  32  ID/EX: PC
- rs1_data_out, rs2_data_out  out  32 each  ID/EX: operand values
- imm_out  out  32  ID/EX: sign-extended immediate
- rs1_out, rs2_out, rd_out  out  5 each  ID/EX: register indices
- funct3_out  out  3  ID/EX: instruction[14:12]
- funct7b5_out  out  1  ID/EX: instruction[30]
- RegWrite_out, MemRead_out, MemWrite_out, Branch_out, Jump_out, ALUSrc_out, MemtoReg_out  out  1 each  ID/EX control
- ALUOp_out  out  2  ID/EX: 00 add, 01 branch compare, 10 R-type, 11 I-ALU

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: all ID/EX outputs are 0 and all 32 registers are cleared to 0 on the reset edge.
- Latency: one cycle from instruction_in to the ID/EX outputs.
- Register-file write: on the clock edge when RegWrite_wb=1 and rd_wb!=0. Writes to x0 are ignored.
- Register-file read: combinational with write-through bypass. If RegWrite_wb=1, rd_wb!=0 and rd_wb equals the source index, read data is wdata_wb. x0 always reads 0.
- Opcode decode:
  - 0110011 R: RegWrite, ALUOp=10.
  - 0010011 I-ALU: RegWrite, ALUSrc, ALUOp=11.
  - 0000011 LOAD: RegWrite, MemRead, MemtoReg, ALUSrc, ALUOp=00.
  - 0100011 STORE: MemWrite, ALUSrc, ALUOp=00.
  - 1100011 BRANCH: Branch, ALUOp=01.
  - 1101111 JAL: RegWrite, Jump.
  - 1100111 JALR: RegWrite, Jump, ALUSrc.
  - 0110111 LUI: RegWrite, ALUSrc, ALUOp=00; rs1_out and rs1_data_out forced to 0.
  - 0010111 AUIPC: RegWrite, ALUSrc, ALUOp=00.
  - Any other opcode, including all-zero: all control 0 (bubble).
- Immediates, each sign-extended from instruction[31]:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R-type and unknown opcodes: imm_out=0.
- rs1 use: every opcode except LUI, AUIPC and JAL.
- rs2 use: R, STORE and BRANCH only.
- Load-use stall: PCWrite=1 when MemRead_ex=1, rd_ex!=0, and rd_ex matches a used source (rs1 or rs2).
- PCWrite override: PCWrite is forced to 0 whenever PCSrc=1, because fetch gives PCWrite priority over PCSrc.
- Edge priority, highest first:
  - reset: clear everything.
  - PCSrc=1: ID/EX loaded with all zeros (flush).
  - stall: control outputs zeroed (bubble). Data, index and PC fields may update; verification checks control only.
  - otherwise: load decoded values.
- Stall release: the held instruction is re-presented by fetch and decoded normally on the next edge.
- Simultaneous writeback and stall: the register-file write still occurs.

Test Plan:
1. reset held 2 cycles, then released with instruction_in=0 -> all outputs 0, PCWrite=0.
2. RegWrite_wb=1, rd_wb=5, wdata_wb=0xDEADBEEF in the same cycle as instruction_in=0x00528333 (add x6,x5,x5) -> next edge rs1_data_out=rs2_data_out=0xDEADBEEF, rd_out=6, RegWrite_out=1, ALUOp_out=10.
3. Write to x0 with 0x1234 -> a later read of x0 returns 0.
4. MemRead_ex=1, rd_ex=5, instruction_in=add x6,x5,x0 -> PCWrite=1 combinationally, control outputs 0 after the edge.
5. Same as 4 with rd_ex=0 -> PCWrite=0.
6. Same as 4 with PCSrc=1 -> PCWrite=0.
7. PCSrc=1 with instruction_in=0xFE000EE3 (beq, imm=-4) -> ID/EX all 0.
8. Same instruction with PCSrc=0 -> imm_out=0xFFFFFFFC, Branch_out=1.
9. instruction_in=0x800000EF (jal, imm=-1048576) -> imm_out=0xFFF00000, Jump_out=1, rd_out=1.
10. instruction_in=0x12345537 (lui x10) -> imm_out=0x12345000, rs1_out=0.
